// File: rtl/mac_norm_stage_if.sv
// Handshake and data bundle for mac_norm_stage.
// master: upstream/downstream environment; slave: the normalizer itself.
interface mac_norm_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] sum_in;
  logic [5:0]  max_exp_in;
  logic [4:0]  Q_frac_in;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] norm_sum_with_leading1;
  logic [4:0]  signed_exp_diff;
  logic        exp_carry;
  logic        sign;
  logic [5:0]  max_exp;
  logic [4:0]  Q_frac;
  logic        inexact;

  modport slave (
    input  in_valid, sum_in, max_exp_in, Q_frac_in, out_ready,
    output in_ready, out_valid, norm_sum_with_leading1, signed_exp_diff,
           exp_carry, sign, max_exp, Q_frac, inexact
  );

  modport master (
    output in_valid, sum_in, max_exp_in, Q_frac_in, out_ready,
    input  in_ready, out_valid, norm_sum_with_leading1, signed_exp_diff,
           exp_carry, sign, max_exp, Q_frac, inexact
  );
endinterface

// File: rtl/mac_norm_stage.sv
// Two-stage normalizer for the MAC accumulator sum.
// S1 registers sign/magnitude; S2 does leading-one detect and shift.
// Optional macro MAC_NORM_ROUND_EN: round-to-nearest-even on right shifts
// instead of truncation (default build truncates).
module mac_norm_stage #(
  parameter int unsigned SUM_W    = 17,
  parameter int unsigned NORM_POS = 10
) (
  input  logic            clk,
  input  logic            rst,
  mac_norm_stage_if.slave bus
);

  localparam int unsigned MANT_W = NORM_POS + 1;
  localparam int unsigned P_W    = 5;

  logic               s1_valid;
  logic               s1_sign;
  logic [SUM_W-1:0]   s1_mag;
  logic [5:0]         s1_max_exp;
  logic [4:0]         s1_q_frac;
  logic               s1_advance;

  logic [P_W-1:0]     lod_p;
  logic [P_W-1:0]     sh;
  logic [SUM_W-1:0]   low_mask;
  logic [MANT_W-1:0]  n_norm;
  logic [4:0]         n_diff;
  logic               n_carry;
  logic               n_inexact;
`ifdef MAC_NORM_ROUND_EN
  logic [SUM_W-1:0]   half_mask;
  logic               half_bit;
  logic               sticky;
  logic [MANT_W:0]    rnd;
`endif

  // Stage loads when empty or when its contents move on this cycle.
  assign s1_advance   = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || s1_advance;

  // S1: capture sign, magnitude and pass-through fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_sign    <= 1'b0;
      s1_mag     <= '0;
      s1_max_exp <= '0;
      s1_q_frac  <= '0;
    end else if (bus.in_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sign    <= bus.sum_in[SUM_W-1];
        s1_mag     <= bus.sum_in[SUM_W-1] ? SUM_W'(-bus.sum_in) : bus.sum_in;
        s1_max_exp <= bus.max_exp_in;
        s1_q_frac  <= bus.Q_frac_in;
      end
    end
  end

  // S2 combinational: leading-one detect, shift, inexact and optional rounding.
  always_comb begin
    lod_p     = '0;
    sh        = '0;
    low_mask  = '0;
    n_norm    = '0;
    n_diff    = '0;
    n_carry   = 1'b0;
    n_inexact = 1'b0;
`ifdef MAC_NORM_ROUND_EN
    half_mask = '0;
    half_bit  = 1'b0;
    sticky    = 1'b0;
    rnd       = '0;
`endif
    for (int i = 0; i < int'(SUM_W); i++) begin
      if (s1_mag[i]) lod_p = P_W'(i);
    end
    if (s1_mag != '0) begin
      n_carry = (lod_p == P_W'(SUM_W - 1));
      n_diff  = n_carry ? 5'd5 : 5'(lod_p - P_W'(NORM_POS));
      if (lod_p < P_W'(NORM_POS)) begin
        n_norm = MANT_W'(s1_mag << (P_W'(NORM_POS) - lod_p));
      end else begin
        sh        = lod_p - P_W'(NORM_POS);
        n_norm    = MANT_W'(s1_mag >> sh);
        low_mask  = (SUM_W'(1) << sh) - SUM_W'(1);
        n_inexact = |(s1_mag & low_mask);
`ifdef MAC_NORM_ROUND_EN
        if (sh != '0) begin
          half_mask = SUM_W'(1) << (sh - P_W'(1));
          half_bit  = |(s1_mag & half_mask);
          sticky    = |(s1_mag & (half_mask - SUM_W'(1)));
          if (half_bit && (sticky || n_norm[0])) begin
            rnd = (MANT_W + 1)'(n_norm) + (MANT_W + 1)'(1);
            if (rnd[MANT_W]) begin
              n_norm = MANT_W'(1) << NORM_POS;
              n_diff = n_diff + 5'd1;
            end else begin
              n_norm = rnd[MANT_W-1:0];
            end
          end
        end
`endif
      end
    end
  end

  // S2 registers: output fields, held while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid              <= 1'b0;
      bus.norm_sum_with_leading1 <= '0;
      bus.signed_exp_diff        <= '0;
      bus.exp_carry              <= 1'b0;
      bus.sign                   <= 1'b0;
      bus.max_exp                <= '0;
      bus.Q_frac                 <= '0;
      bus.inexact                <= 1'b0;
    end else if (s1_advance) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.norm_sum_with_leading1 <= n_norm;
        bus.signed_exp_diff        <= n_diff;
        bus.exp_carry              <= n_carry;
        bus.sign                   <= s1_sign;
        bus.max_exp                <= s1_max_exp;
        bus.Q_frac                 <= s1_q_frac;
        bus.inexact                <= n_inexact;
      end
    end
  end

endmodule

// File: tb/tb_mac_norm_stage.sv
// Scoreboard bench for mac_norm_stage: driver pushes expected results,
// negedge monitor pops and compares on every output transfer.
module tb_mac_norm_stage;

  typedef struct packed {
    logic        sign;
    logic [10:0] norm;
    logic [4:0]  diff;
    logic        carry;
    logic        inexact;
    logic [5:0]  me;
    logic [4:0]  qf;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   occ = 0;
  bit   mon_en = 1'b0;
  bit   held_prev = 1'b0;
  bit   saw_block = 1'b0;
  res_t snap;
  res_t exp_q[$];

  mac_norm_stage_if bus ();

  mac_norm_stage u_dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic res_t cur_out();
    return {bus.sign, bus.norm_sum_with_leading1, bus.signed_exp_diff,
            bus.exp_carry, bus.inexact, bus.max_exp, bus.Q_frac};
  endfunction

  // Monitor: checks transfers, held-output stability and in_ready.
  always @(negedge clk) begin
    res_t c, e;
    bit   acc, emit, exp_rdy;
    if (mon_en) begin
      c = cur_out();
      exp_rdy = (occ < 2) || bus.out_ready;
      checks++;
      if (bus.in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL in_ready: got %b want %b (occ %0d)", bus.in_ready, exp_rdy, occ);
      end
      if (bus.in_ready === 1'b0) saw_block = 1'b1;
      if (held_prev && !rst) begin
        checks++;
        if (bus.out_valid !== 1'b1 || c !== snap) begin
          errors++;
          $display("FAIL hold: got v=%b %h want v=1 %h", bus.out_valid, c, snap);
        end
      end
      acc  = bus.in_valid && bus.in_ready;
      emit = bus.out_valid && bus.out_ready;
      if (rst) begin
        exp_q.delete();
        occ = 0;
        held_prev = 1'b0;
      end else begin
        if (emit) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out: got %h want none", c);
          end else begin
            e = exp_q.pop_front();
            if (c !== e) begin
              errors++;
              $display("FAIL data: got %h want %h", c, e);
            end
          end
        end
        occ = occ + int'(acc) - int'(emit);
        held_prev = bus.out_valid && !bus.out_ready;
        snap = c;
      end
    end
  end

  // Drive one input; push its expected result when the handshake completes.
  task automatic send(input logic [16:0] s, input logic [5:0] me, input logic [4:0] qf,
                      input logic sg, input logic [10:0] nm, input logic [4:0] df,
                      input logic cy, input logic ix);
    bit done = 1'b0;
    bus.in_valid   = 1'b1;
    bus.sum_in     = s;
    bus.max_exp_in = me;
    bus.Q_frac_in  = qf;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1 && !rst) begin
        exp_q.push_back({sg, nm, df, cy, ix, me, qf});
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 want 1 for sum %h", s);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic check_idle(input string nm);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_out_valid: got %b want 0", nm, bus.out_valid);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_in_ready: got %b want 1", nm, bus.in_ready);
    end
    checks++;
    if (cur_out() !== '0) begin
      errors++;
      $display("FAIL %s_fields: got %h want 0", nm, cur_out());
    end
  endtask

  task automatic drain(input string nm);
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d pending want 0", nm, exp_q.size());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid   = 1'b0;
    bus.sum_in     = '0;
    bus.max_exp_in = '0;
    bus.Q_frac_in  = '0;
    bus.out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle("reset");
    mon_en = 1'b1;

    // Directed single vectors
    send(17'd1024,   6'd1, 5'd2, 1'b0, 11'h400, 5'd0,  1'b0, 1'b0);
    send(17'h1FFFD,  6'd2, 5'd3, 1'b1, 11'h600, 5'h17, 1'b0, 1'b0);
    send(17'h10000,  6'd3, 5'd4, 1'b1, 11'h400, 5'd5,  1'b1, 1'b0);
`ifdef MAC_NORM_ROUND_EN
    send(17'd65535,  6'd4, 5'd5, 1'b0, 11'h400, 5'd6,  1'b0, 1'b1);
    send(17'd3071,   6'd5, 5'd6, 1'b0, 11'h600, 5'd1,  1'b0, 1'b1);
`else
    send(17'd65535,  6'd4, 5'd5, 1'b0, 11'h7FF, 5'd5,  1'b0, 1'b1);
    send(17'd3071,   6'd5, 5'd6, 1'b0, 11'h5FF, 5'd1,  1'b0, 1'b1);
`endif
    send(17'h1FBFF,  6'd6, 5'd7, 1'b1, 11'h401, 5'd0,  1'b0, 1'b0);
    send(17'd6144,   6'd7, 5'd8, 1'b0, 11'h600, 5'd2,  1'b0, 1'b0);
    send(17'd0,      6'd20, 5'd3, 1'b0, 11'h000, 5'd0, 1'b0, 1'b0);
    drain("single");

    // Back-to-back stream with a three-cycle downstream stall
    @(posedge clk);
    #1;
    saw_block = 1'b0;
    fork
      begin
        send(17'd1, 6'd11, 5'd1, 1'b0, 11'h400, 5'h16, 1'b0, 1'b0);
        send(17'd2, 6'd12, 5'd2, 1'b0, 11'h400, 5'h17, 1'b0, 1'b0);
        send(17'd3, 6'd13, 5'd3, 1'b0, 11'h600, 5'h17, 1'b0, 1'b0);
        send(17'd4, 6'd14, 5'd4, 1'b0, 11'h400, 5'h18, 1'b0, 1'b0);
        send(17'd5, 6'd15, 5'd5, 1'b0, 11'h500, 5'h18, 1'b0, 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain("stream");
    checks++;
    if (!saw_block) begin
      errors++;
      $display("FAIL stall_block: got in_ready never low want low during stall");
    end

    // Reset with both stages full
    bus.out_ready = 1'b0;
    send(17'd1024, 6'd9, 5'd9, 1'b0, 11'h400, 5'd0, 1'b0, 1'b0);
    send(17'd2048, 6'd9, 5'd9, 1'b0, 11'h400, 5'd1, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle("rst_full");
    bus.out_ready = 1'b1;
    send(17'd1024, 6'd21, 5'd4, 1'b0, 11'h400, 5'd0, 1'b0, 1'b0);
    drain("recover");

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
